// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program-counter unit.
package pc_pkg;
  typedef enum logic [1:0] {SEQ = 2'd0, BRANCH = 2'd1, JUMP = 2'd2, JREG = 2'd3} pc_mode_t;
  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} pc_state_t;
endpackage

// File: rtl/target_shift.sv
// Zero-fill left shift used to turn a word offset into a byte offset.
module target_shift #(
  parameter int W     = 32,
  parameter int SHIFT = 2
) (
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);
  assign out_o = in_i << SHIFT;
endmodule

// File: rtl/next_pc_unit.sv
// Architectural fetch PC: sequential advance, branch/jump/register redirects,
// and a one-deep buffer for redirects that arrive while fetch is stalled.
module next_pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              SHIFT       = 2,
  parameter int              INSTR_BYTES = 4,
  parameter int              JIDX_W      = 26,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              redir_valid_i,
  input  pc_mode_t          redir_mode_i,
  input  logic [XLEN-1:0]   br_pc_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [JIDX_W-1:0] jidx_i,
  input  logic [XLEN-1:0]   reg_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   pc_plus_o,
  output logic              pend_o,
  output logic              misalign_o
);
  localparam logic [XLEN-1:0] INC        = XLEN'(INSTR_BYTES);
  // Masks instead of slices so SHIFT=0 and JIDX_W+SHIFT=XLEN stay legal.
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << SHIFT) - XLEN'(1);
  localparam logic [XLEN-1:0] JHI_MASK   = ~((XLEN'(1) << (JIDX_W + SHIFT)) - XLEN'(1));

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_mis_q, pend_mis_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] seq, imm_sh, tgt;
  logic            tgt_mis, redir_live;

  target_shift #(.W(XLEN), .SHIFT(SHIFT)) u_br_shift (
    .in_i  (imm_i),
    .out_o (imm_sh)
  );

  assign seq        = br_pc_i + INC;
  assign redir_live = redir_valid_i && (redir_mode_i != SEQ);

  always_comb begin
    tgt     = seq;
    tgt_mis = 1'b0;
    case (redir_mode_i)
      BRANCH:  tgt = seq + imm_sh;
      JUMP:    tgt = (seq & JHI_MASK) | (XLEN'(jidx_i) << SHIFT);
      JREG: begin
        tgt     = reg_i & ~ALIGN_MASK;
        tgt_mis = |(reg_i & ALIGN_MASK);
      end
      default: tgt = seq;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_mis_d = pend_mis_q;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stall_i) begin
          if (redir_live) begin
            pc_d       = tgt;
            misalign_d = tgt_mis;
          end else begin
            pc_d = pc_q + INC;
          end
        end else if (redir_live) begin
          pend_tgt_d = tgt;
          pend_mis_d = tgt_mis;
          state_d    = PENDING;
        end
      end
      PENDING: begin
        if (stall_i) begin
          if (redir_live) begin
            pend_tgt_d = tgt;
            pend_mis_d = tgt_mis;
          end
        end else begin
          // Buffered redirect is older than anything live this cycle.
          pc_d       = pend_tgt_q;
          misalign_d = pend_mis_q;
          pend_tgt_d = '0;
          pend_mis_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      pend_mis_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_mis_q <= pend_mis_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus_o  = pc_q + INC;
  assign pend_o     = (state_q == PENDING);
  assign misalign_o = misalign_q;
endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboarded bench for next_pc_unit: expected PC/pend/misalign per cycle
// are queued with the stimulus and compared after the clock edge.
module tb_next_pc_unit;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redir_valid_i = 1'b0;
  pc_mode_t    redir_mode_i = SEQ;
  logic [31:0] br_pc_i = '0, imm_i = '0, reg_i = '0;
  logic [25:0] jidx_i = '0;
  logic [31:0] pc_o, pc_plus_o;
  logic        pend_o, misalign_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        stall;
    logic        valid;
    pc_mode_t    mode;
    logic [31:0] br;
    logic [31:0] imm;
    logic [25:0] jidx;
    logic [31:0] rg;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  next_pc_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redir_valid_i (redir_valid_i),
    .redir_mode_i  (redir_mode_i),
    .br_pc_i       (br_pc_i),
    .imm_i         (imm_i),
    .jidx_i        (jidx_i),
    .reg_i         (reg_i),
    .pc_o          (pc_o),
    .pc_plus_o     (pc_plus_o),
    .pend_o        (pend_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(logic st, logic v, pc_mode_t m, logic [31:0] br,
                               logic [31:0] imm, logic [25:0] jx, logic [31:0] rg);
    stim_t s;
    s.stall = st; s.valid = v; s.mode = m; s.br = br; s.imm = imm; s.jidx = jx; s.rg = rg;
    return s;
  endfunction

  function automatic exp_t ex(logic [31:0] pc, logic pend, logic mis);
    exp_t e;
    e.pc = pc; e.pend = pend; e.mis = mis;
    return e;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, sample #1 after the edge.
  task automatic apply(input stim_t s, input exp_t e);
    stall_i = s.stall; redir_valid_i = s.valid; redir_mode_i = s.mode;
    br_pc_i = s.br; imm_i = s.imm; jidx_i = s.jidx; reg_i = s.rg;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  stim_t IDL;

  task automatic test_reset();
    exp_t g;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(ex(32'h0040_0000, 1'b0, 1'b0));
    g = sb.pop_front();
    n_tests += 4;
    if (pc_o !== g.pc) begin n_fail++; $display("FAIL reset pc_o got %h want %h", pc_o, g.pc); end
    if (pc_plus_o !== g.pc + 32'd4) begin n_fail++; $display("FAIL reset pc_plus_o got %h want %h", pc_plus_o, g.pc + 32'd4); end
    if (pend_o !== g.pend) begin n_fail++; $display("FAIL reset pend_o got %b want %b", pend_o, g.pend); end
    if (misalign_o !== g.mis) begin n_fail++; $display("FAIL reset misalign_o got %b want %b", misalign_o, g.mis); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_seq();
    exp_t g;
    for (int i = 0; i < 3; i++) begin
      apply(IDL, ex(32'h0040_0004 + 32'(i) * 32'd4, 1'b0, 1'b0));
      g = sb.pop_front();
      n_tests += 3;
      if (pc_o !== g.pc) begin n_fail++; $display("FAIL seq[%0d] pc_o got %h want %h", i, pc_o, g.pc); end
      if (pc_plus_o !== g.pc + 32'd4) begin n_fail++; $display("FAIL seq[%0d] pc_plus_o got %h want %h", i, pc_plus_o, g.pc + 32'd4); end
      if (pend_o !== g.pend) begin n_fail++; $display("FAIL seq[%0d] pend_o got %b want %b", i, pend_o, g.pend); end
    end
  endtask

  task automatic test_redirects();
    stim_t st[6];
    exp_t  e[6];
    exp_t  g;
    st[0] = mk(0, 1, BRANCH, 32'h0040_0010, 32'hFFFF_FFFC, '0, '0);      e[0] = ex(32'h0040_0004, 0, 0);
    st[1] = IDL;                                                         e[1] = ex(32'h0040_0008, 0, 0);
    st[2] = mk(0, 1, JUMP, 32'h1000_0020, '0, 26'h000_0100, '0);         e[2] = ex(32'h1000_0400, 0, 0);
    st[3] = mk(0, 1, SEQ, 32'h0000_1000, 32'h10, 26'h3, 32'h5000);       e[3] = ex(32'h1000_0404, 0, 0);
    st[4] = mk(0, 1, JREG, '0, '0, '0, 32'h0040_0023);                   e[4] = ex(32'h0040_0020, 0, 1);
    st[5] = IDL;                                                         e[5] = ex(32'h0040_0024, 0, 0);
    for (int i = 0; i < 6; i++) begin
      apply(st[i], e[i]);
      g = sb.pop_front();
      n_tests += 3;
      if (pc_o !== g.pc) begin n_fail++; $display("FAIL redir[%0d] pc_o got %h want %h", i, pc_o, g.pc); end
      if (pend_o !== g.pend) begin n_fail++; $display("FAIL redir[%0d] pend_o got %b want %b", i, pend_o, g.pend); end
      if (misalign_o !== g.mis) begin n_fail++; $display("FAIL redir[%0d] misalign_o got %b want %b", i, misalign_o, g.mis); end
    end
  endtask

  task automatic test_stall_pending();
    stim_t st[5];
    exp_t  e[5];
    exp_t  g;
    st[0] = mk(1, 1, BRANCH, 32'h0040_00FC, 32'h0, '0, '0);              e[0] = ex(32'h0040_0024, 1, 0);
    st[1] = mk(1, 1, JUMP, 32'h0000_0000, '0, 26'h80, '0);              e[1] = ex(32'h0040_0024, 1, 0);
    st[2] = mk(1, 0, SEQ, '0, '0, '0, '0);                              e[2] = ex(32'h0040_0024, 1, 0);
    st[3] = mk(0, 1, JREG, '0, '0, '0, 32'h0000_0300);                  e[3] = ex(32'h0000_0200, 0, 0);
    st[4] = IDL;                                                        e[4] = ex(32'h0000_0204, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(st[i], e[i]);
      g = sb.pop_front();
      n_tests += 3;
      if (pc_o !== g.pc) begin n_fail++; $display("FAIL stall[%0d] pc_o got %h want %h", i, pc_o, g.pc); end
      if (pend_o !== g.pend) begin n_fail++; $display("FAIL stall[%0d] pend_o got %b want %b", i, pend_o, g.pend); end
      if (misalign_o !== g.mis) begin n_fail++; $display("FAIL stall[%0d] misalign_o got %b want %b", i, misalign_o, g.mis); end
    end
  endtask

  task automatic test_wrap();
    stim_t st[3];
    exp_t  e[3];
    exp_t  g;
    st[0] = mk(0, 1, JREG, '0, '0, '0, 32'hFFFF_FFFC);                  e[0] = ex(32'hFFFF_FFFC, 0, 0);
    st[1] = IDL;                                                        e[1] = ex(32'h0000_0000, 0, 0);
    st[2] = IDL;                                                        e[2] = ex(32'h0000_0004, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(st[i], e[i]);
      g = sb.pop_front();
      n_tests += 3;
      if (pc_o !== g.pc) begin n_fail++; $display("FAIL wrap[%0d] pc_o got %h want %h", i, pc_o, g.pc); end
      if (pc_plus_o !== g.pc + 32'd4) begin n_fail++; $display("FAIL wrap[%0d] pc_plus_o got %h want %h", i, pc_plus_o, g.pc + 32'd4); end
      if (misalign_o !== g.mis) begin n_fail++; $display("FAIL wrap[%0d] misalign_o got %b want %b", i, misalign_o, g.mis); end
    end
  endtask

  task automatic test_reset_pending();
    exp_t g;
    apply(mk(1, 1, BRANCH, 32'h0040_00FC, 32'h0, '0, '0), ex(32'h0000_0004, 1, 0));
    g = sb.pop_front();
    n_tests += 2;
    if (pc_o !== g.pc) begin n_fail++; $display("FAIL rstpend capture pc_o got %h want %h", pc_o, g.pc); end
    if (pend_o !== g.pend) begin n_fail++; $display("FAIL rstpend capture pend_o got %b want %b", pend_o, g.pend); end
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(ex(32'h0040_0000, 1'b0, 1'b0));
    g = sb.pop_front();
    n_tests += 2;
    if (pc_o !== g.pc) begin n_fail++; $display("FAIL rstpend async pc_o got %h want %h", pc_o, g.pc); end
    if (pend_o !== g.pend) begin n_fail++; $display("FAIL rstpend async pend_o got %b want %b", pend_o, g.pend); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) apply(mk(1, 0, SEQ, '0, '0, '0, '0), ex(32'h0040_0000, 0, 0));
      else        apply(IDL, ex(32'h0040_0004, 0, 0));
      g = sb.pop_front();
      n_tests += 3;
      if (pc_o !== g.pc) begin n_fail++; $display("FAIL rstpend[%0d] pc_o got %h want %h", i, pc_o, g.pc); end
      if (pend_o !== g.pend) begin n_fail++; $display("FAIL rstpend[%0d] pend_o got %b want %b", i, pend_o, g.pend); end
      if (misalign_o !== g.mis) begin n_fail++; $display("FAIL rstpend[%0d] misalign_o got %b want %b", i, misalign_o, g.mis); end
    end
  endtask

  initial begin
    IDL = mk(0, 0, SEQ, '0, '0, '0, '0);
    test_reset();
    test_seq();
    test_redirects();
    test_stall_pending();
    test_wrap();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Parametrised program-counter unit for the fetch stage: holds the architectural PC and computes the next PC as sequential, PC-relative branch, pseudo-absolute jump or register jump. Branch/jump target arithmetic uses a configurable shift-left of the offset/index field, generalising the fixed shift-by-2 target logic. Redirects raised while fetch is stalled are buffered and applied when the stall clears. Sits between the decode/execute redirect sources and the instruction-memory address port.

## Interface
- XLEN, 32, PC and data width in bits
- SHIFT, 2, left shift applied to branch offset and jump index (log2 of instruction alignment)
- INSTR_BYTES, 4, sequential increment; must equal 2**SHIFT
- JIDX_W, 26, jump index width; XLEN >= JIDX_W+SHIFT
- RESET_PC, 32'h0040_0000, PC value after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold PC this cycle
- redir_valid_i  in  1  redirect request (taken branch/jump) this cycle
- redir_mode_i  in  2  pc_mode_t: SEQ, BRANCH, JUMP, JREG
- br_pc_i  in  XLEN  PC of the redirecting instruction
- imm_i  in  XLEN  sign-extended word offset (BRANCH)
- jidx_i  in  JIDX_W  jump index (JUMP)
- reg_i  in  XLEN  register target (JREG)
- pc_o  out  XLEN  current fetch PC, registered
- pc_plus_o  out  XLEN  pc_o + INSTR_BYTES, combinational from pc_o
- pend_o  out  1  buffered redirect outstanding
- misalign_o  out  1  one-cycle pulse: JREG target had nonzero low SHIFT bits

## Operation
- Target calc (combinational), seq = br_pc_i + INSTR_BYTES, all sums modulo 2**XLEN:
  - BRANCH: seq + (imm_i << SHIFT), bits shifted out discarded
  - JUMP: {seq[XLEN-1:JIDX_W+SHIFT], jidx_i, SHIFT zeros}
  - JREG: {reg_i[XLEN-1:SHIFT], SHIFT zeros}; misaligned flag = |reg_i[SHIFT-1:0]
  - SEQ with redir_valid_i: treated as no redirect (ignored)
- FSM states IDLE, PENDING:
  - IDLE, stall_i=0, valid redirect: pc_o <= target; misalign_o <= flag
  - IDLE, stall_i=0, no redirect: pc_o <= pc_o + INSTR_BYTES
  - IDLE, stall_i=1, valid redirect: capture target+flag in pending reg -> PENDING; pc_o held
  - IDLE, stall_i=1, none: pc_o held
  - PENDING, stall_i=1: pc_o held; a new valid redirect overwrites pending reg
  - PENDING, stall_i=0: pc_o <= pending target, misalign_o <= stored flag, -> IDLE; any simultaneous live redirect is dropped (pending is older in program order)
- misalign_o never blocks the redirect; the aligned target is always used.

## Timing
- Reset (async assert, sync deassert by clk): pc_o=RESET_PC, pc_plus_o=RESET_PC+INSTR_BYTES, pend_o=0, misalign_o=0, state IDLE, pending reg cleared.
- Redirect latency: 1 cycle from sampled redir_valid_i (stall low) to pc_o=target.
- Stall: pc_o stable for every cycle stall_i=1; release applies pending target on the first edge with stall_i=0.
- pend_o = (state==PENDING), registered; rises the cycle after capture, falls with the pc_o update.
- misalign_o high exactly one cycle, coincident with pc_o showing the aligned target.
- Sequential wrap: 2**XLEN-INSTR_BYTES -> 0, no flag.
- Reset mid-PENDING discards the buffered redirect.

## Structure
- pc_pkg: pc_mode_t enum (SEQ=0, BRANCH=1, JUMP=2, JREG=3), pc_state_t enum (IDLE, PENDING).
- Sub-module target_shift (parameters W, SHIFT): combinational left shift with zero fill, instanced for the branch offset; jump concatenation inline.

## Test plan
- Reset then 3 unstalled cycles -> pc_o 0x0040_0000, 0x0040_0004, 0x0040_0008, 0x0040_000C; pend_o=0.
- BRANCH br_pc_i=0x0040_0010, imm_i=0xFFFF_FFFC -> next pc_o=0x0040_0004.
- JUMP br_pc_i=0x1000_0020, jidx_i=0x000_0100 -> pc_o=0x1000_0400.
- JREG reg_i=0x0040_0023 -> pc_o=0x0040_0020, misalign_o=1 for one cycle.
- stall_i=1, BRANCH to 0x0040_0100 then JUMP to 0x0000_0200 during stall -> pc_o held, pend_o=1; stall released with live redirect to 0x0000_0300 -> pc_o=0x0000_0200, pend_o=0.
- pc_o=0xFFFF_FFFC unstalled -> 0x0000_0000; rst_n pulsed while PENDING -> pc_o=0x0040_0000, pend_o=0, no later redirect.
